feature_buffer_pingpong: RTL and testbench

- Double-buffered (ping-pong) feature-map store for a conv/pool layer output ahead of the next layer or FC stage.
- Accepts LANES signed elements per write beat into the fill bank.
- Presents the other, completed bank as one flat CO*SIZE*SIZE parallel vector.
- Valid/ready write handshake and valid/release read handshake allow fill and consume to overlap.

---
 rtl/feature_buffer_pingpong.sv | 122 ++++++++++++
 tb/tb_feature_buffer_pingpong.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/feature_buffer_pingpong.sv
// Ping-pong feature-map store: one bank fills LANES elements per beat while the other, completed bank is presented flat.
// Optional macro FEATBUF_RELU_EN rectifies each lane on write (negative values stored as zero).
module feature_buffer_pingpong #(
  parameter int BW    = 8,
  parameter int SIZE  = 5,
  parameter int CO    = 4,
  parameter int LANES = 1
) (
  input  logic                        clk,
  input  logic                        global_rst_n,
  input  logic                        rst_processEnd,
  input  logic                        ce,
  input  logic                        i_valid,
  input  logic [LANES*BW-1:0]         i_data,
  output logic                        o_ready,
  output logic                        o_valid,
  output logic [CO*SIZE*SIZE*BW-1:0]  o_data,
  input  logic                        i_release,
  output logic                        o_empty,
  output logic                        o_full,
  output logic [1:0]                  o_bank_cnt
);

  localparam int DEPTH = CO * SIZE * SIZE;
  localparam int WORDS = DEPTH / LANES;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [BW-1:0] mem_r [2][DEPTH];
  logic [1:0]    full_r;
  logic          wr_bank_r;
  logic          rd_bank_r;
  logic [CW-1:0] wr_cnt_r;

  logic          accept_s;
  logic          release_s;
  logic          last_s;
  logic [BW-1:0] lane_s [LANES];

  function automatic logic [BW-1:0] rectify(input logic [BW-1:0] v);
`ifdef FEATBUF_RELU_EN
    if (v[BW-1]) begin
      rectify = {BW{1'b0}};
    end else begin
      rectify = v;
    end
`else
    rectify = v;
`endif
  endfunction

  // A full bank is never writable, and a release only acts on a full bank, so the two never target the same bank.
  assign o_ready   = ce & ~full_r[wr_bank_r];
  assign accept_s  = i_valid & o_ready;
  assign release_s = ce & i_release & full_r[rd_bank_r];
  assign last_s    = (wr_cnt_r == CW'(WORDS - 1));

  assign o_valid    = full_r[rd_bank_r];
  assign o_full     = full_r[0] & full_r[1];
  assign o_empty    = ~full_r[0] & ~full_r[1] & (wr_cnt_r == {CW{1'b0}});
  assign o_bank_cnt = {1'b0, full_r[0]} + {1'b0, full_r[1]};

  // Per-lane write data after optional rectification.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_s[l] = rectify(i_data[l*BW +: BW]);
    end
  end

  // Bank pointers, completion flags and fill counter.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      wr_cnt_r  <= {CW{1'b0}};
    end else if (rst_processEnd) begin
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      wr_cnt_r  <= {CW{1'b0}};
    end else if (ce) begin
      if (accept_s) begin
        if (last_s) begin
          wr_cnt_r          <= {CW{1'b0}};
          full_r[wr_bank_r] <= 1'b1;
          wr_bank_r         <= ~wr_bank_r;
        end else begin
          wr_cnt_r <= wr_cnt_r + CW'(1);
        end
      end
      if (release_s) begin
        full_r[rd_bank_r] <= 1'b0;
        rd_bank_r         <= ~rd_bank_r;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar k = 0; k < DEPTH; k++) begin : g_elem
      localparam int LN = k % LANES;
      localparam int WD = k / LANES;
      logic wr_en_s;
      assign wr_en_s = accept_s && (wr_bank_r == b[0]) && (wr_cnt_r == CW'(WD));

      // Storage element; cleared by both resets, written only when its bank, word and lane match.
      always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
          mem_r[b][k] <= {BW{1'b0}};
        end else if (rst_processEnd) begin
          mem_r[b][k] <= {BW{1'b0}};
        end else if (wr_en_s) begin
          mem_r[b][k] <= lane_s[LN];
        end
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_out
    assign o_data[k*BW +: BW] = mem_r[rd_bank_r][k];
  end

endmodule

// File: tb/tb_feature_buffer_pingpong.sv
// Directed bench for feature_buffer_pingpong with BW=8, SIZE=2, CO=2, LANES=2 (DEPTH=8, WORDS=4).
module tb_feature_buffer_pingpong;

  logic        clk;
  logic        global_rst_n;
  logic        rst_processEnd;
  logic        ce;
  logic        i_valid;
  logic [15:0] i_data;
  logic        o_ready;
  logic        o_valid;
  logic [63:0] o_data;
  logic        i_release;
  logic        o_empty;
  logic        o_full;
  logic [1:0]  o_bank_cnt;

  int n_cmp;
  int n_bad;

  feature_buffer_pingpong #(.BW(8), .SIZE(2), .CO(2), .LANES(2)) dut (
    .clk(clk), .global_rst_n(global_rst_n), .rst_processEnd(rst_processEnd), .ce(ce),
    .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready), .o_valid(o_valid),
    .o_data(o_data), .i_release(i_release), .o_empty(o_empty), .o_full(o_full),
    .o_bank_cnt(o_bank_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; sampling happens 1 time unit after the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic rel);
    i_valid   = v;
    i_data    = d;
    i_release = rel;
    @(posedge clk);
    #1;
    i_valid   = 1'b0;
    i_release = 1'b0;
  endtask

  task automatic status(input string tag, input logic v, input logic rdy, input logic [1:0] cnt,
                        input logic emp, input logic ful);
    chk_value({tag, ".valid"}, {63'd0, o_valid}, {63'd0, v});
    chk_value({tag, ".ready"}, {63'd0, o_ready}, {63'd0, rdy});
    chk_value({tag, ".cnt"},   {62'd0, o_bank_cnt}, {62'd0, cnt});
    chk_value({tag, ".empty"}, {63'd0, o_empty}, {63'd0, emp});
    chk_value({tag, ".full"},  {63'd0, o_full}, {63'd0, ful});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    global_rst_n   = 1'b0;
    rst_processEnd = 1'b0;
    ce             = 1'b1;
    i_valid        = 1'b0;
    i_data         = 16'h0000;
    i_release      = 1'b0;
    #12;
    status("reset", 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
    chk_value("reset.data", o_data, 64'h0);
    @(posedge clk);
    #1;
    global_rst_n = 1'b1;

    // Fill bank 0 with 1..8
    step(1'b1, 16'h0201, 1'b0);
    step(1'b1, 16'h0403, 1'b0);
    step(1'b1, 16'h0605, 1'b0);
    status("fill3", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 16'h0807, 1'b0);
    status("fill4", 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    chk_value("fill4.data", o_data, 64'h0807060504030201);

    // Fill bank 1 with 9..16, then a 9th beat must be refused
    step(1'b1, 16'h0A09, 1'b0);
    step(1'b1, 16'h0C0B, 1'b0);
    step(1'b1, 16'h0E0D, 1'b0);
    step(1'b1, 16'h100F, 1'b0);
    status("both", 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    step(1'b1, 16'h6363, 1'b0);
    status("beat9", 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    chk_value("beat9.data", o_data, 64'h0807060504030201);

    // Release bank 0
    step(1'b0, 16'h0000, 1'b1);
    status("rel", 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    chk_value("rel.data", o_data, 64'h100F0E0D0C0B0A09);

    // Refill bank 0; final beat coincides with release of bank 1
    step(1'b1, 16'h1211, 1'b0);
    step(1'b1, 16'h1413, 1'b0);
    step(1'b1, 16'h1615, 1'b0);
    step(1'b1, 16'h1817, 1'b1);
    status("sim0", 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    chk_value("sim0.data", o_data, 64'h1817161514131211);

    // Fill bank 1; final beat coincides with release of bank 0
    step(1'b1, 16'h2221, 1'b0);
    step(1'b1, 16'h2423, 1'b0);
    step(1'b1, 16'h2625, 1'b0);
    step(1'b1, 16'h2827, 1'b1);
    status("sim1", 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    chk_value("sim1.data", o_data, 64'h2827262524232221);

    // Two beats into bank 0, then ce low for 3 cycles with write and release requested
    step(1'b1, 16'h3231, 1'b0);
    step(1'b1, 16'h3433, 1'b0);
    ce = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 16'h7777, 1'b1);
      status("ce_off", 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
      chk_value("ce_off.data", o_data, 64'h2827262524232221);
    end
    ce = 1'b1;
    step(1'b1, 16'h3635, 1'b0);
    step(1'b1, 16'h3837, 1'b0);
    status("ce_fill", 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    chk_value("ce_rel.data", o_data, 64'h3837363534333231);

    // Partial fill of bank 1, then synchronous end-of-image clear
    step(1'b1, 16'h4241, 1'b0);
    step(1'b1, 16'h4443, 1'b0);
    rst_processEnd = 1'b1;
    step(1'b0, 16'h0000, 1'b0);
    rst_processEnd = 1'b0;
    status("pend", 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
    chk_value("pend.data", o_data, 64'h0);
    step(1'b1, 16'h5251, 1'b0);
    step(1'b1, 16'h5453, 1'b0);
    step(1'b1, 16'h5655, 1'b0);
    step(1'b1, 16'h5857, 1'b0);
    status("pend_fill", 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    chk_value("pend_fill.data", o_data, 64'h5857565554535251);

    // Partial fill of bank 1, then asynchronous reset between edges
    step(1'b1, 16'h6261, 1'b0);
    step(1'b1, 16'h6463, 1'b0);
    global_rst_n = 1'b0;
    #2;
    status("arst", 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
    chk_value("arst.data", o_data, 64'h0);
    global_rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h7271, 1'b0);
    step(1'b1, 16'h7473, 1'b0);
    step(1'b1, 16'h7675, 1'b0);
    step(1'b1, 16'h7877, 1'b0);
    status("arst_fill", 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    chk_value("arst_fill.data", o_data, 64'h7877767574737271);

    // Negative lanes: rectified only when the macro is defined
    step(1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'h05FD, 1'b0);
    step(1'b1, 16'h7F80, 1'b0);
    step(1'b1, 16'hFF00, 1'b0);
    step(1'b1, 16'h0201, 1'b0);
    chk_value("neg.valid", {63'd0, o_valid}, 64'd1);
`ifdef FEATBUF_RELU_EN
    chk_value("neg.data", o_data, 64'h020100007F000500);
`else
    chk_value("neg.data", o_data, 64'h0201FF007F8005FD);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
